// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: next-PC select encodings and fetch FSM states shared with the branch unit
package pc_unit_pkg;
  typedef enum logic [1:0] {
    SRC_NORM  = 2'b00,
    SRC_FW    = 2'b01,
    SRC_DATAB = 2'b10,
    SRC_RSVD  = 2'b11
  } pc_src_e;
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/pc_unit.sv
// pc_unit: program counter with boot-vector fetch, branch/return redirect, stall hold and redirect statistics
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] BOOT_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_src,
  input  logic            b_take,
  input  logic [PC_W-1:0] target_fw,
  input  logic [PC_W-1:0] target_mem,
  input  logic            stall,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  output logic            flush,
  output logic            fetch_valid,
  output logic [7:0]      redirect_cnt,
  output logic            src_err
);
  state_e          state_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            run, take_fw, take_mem, redir, rsvd;
  pc_src_e         src;
  assign src = pc_src_e'(pc_src);
  // next-PC mux: boot vector, then redirects over stall, reserved select holds
  always_comb begin
    run      = state_q == ST_RUN;
    take_fw  = src == SRC_FW && b_take;
    take_mem = src == SRC_DATAB;
    redir    = run && (take_fw || take_mem);
    rsvd     = run && src == SRC_RSVD;
    pc_d     = !run ? imem_rdata :
               take_mem ? target_mem :
               take_fw ? target_fw :
               (rsvd || stall) ? pc_q : pc_q + 1'b1;
    cnt_d    = (redir && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    err_d    = err_q | rsvd;
  end
  // BOOT lasts one cycle, then RUN until the next reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= BOOT_ADDR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= ST_RUN;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign pc           = pc_q;
  assign pc_plus1     = pc_q + 1'b1;
  assign flush        = redir;
  assign fetch_valid  = state_q == ST_RUN;
  assign redirect_cnt = cnt_q;
  assign src_err      = err_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed stimulus with a behavioural next-PC model checked every cycle
module tb_pc_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] pc_src = 2'b00;
  logic       b_take = 1'b0;
  logic [7:0] target_fw = 8'h00;
  logic [7:0] target_mem = 8'h00;
  logic       stall = 1'b0;
  logic [7:0] imem_rdata = 8'h40;
  logic [7:0] pc, pc_plus1, redirect_cnt;
  logic       flush, fetch_valid, src_err;
  int n_tests = 0;
  int n_fail = 0;
  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .b_take(b_take),
    .target_fw(target_fw), .target_mem(target_mem), .stall(stall),
    .imem_rdata(imem_rdata), .pc(pc), .pc_plus1(pc_plus1), .flush(flush),
    .fetch_valid(fetch_valid), .redirect_cnt(redirect_cnt), .src_err(src_err)
  );
  always #5 clk = ~clk;
  // reference model: plain integers, redirect count unbounded and clipped on compare
  bit m_boot;
  int m_pc, m_cnt;
  bit m_err;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot <= 1'b1;
      m_pc   <= 0;
      m_cnt  <= 0;
      m_err  <= 1'b0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
      m_pc   <= int'(imem_rdata);
    end else if (pc_src == 2'd2) begin
      m_pc  <= int'(target_mem);
      m_cnt <= m_cnt + 1;
    end else if (pc_src == 2'd1 && b_take) begin
      m_pc  <= int'(target_fw);
      m_cnt <= m_cnt + 1;
    end else if (pc_src == 2'd3) begin
      m_err <= 1'b1;
    end else if (!stall) begin
      m_pc <= (m_pc + 1) % 256;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("m_pc", {24'd0, pc}, m_pc);
    chk("m_pc_plus1", {24'd0, pc_plus1}, (m_pc + 1) % 256);
    chk("m_fetch_valid", {31'd0, fetch_valid}, {31'd0, !m_boot});
    chk("m_flush", {31'd0, flush},
        {31'd0, !m_boot && rst_n && (pc_src == 2'd2 || (pc_src == 2'd1 && b_take))});
    chk("m_cnt", {24'd0, redirect_cnt}, m_cnt > 255 ? 255 : m_cnt);
    chk("m_src_err", {31'd0, src_err}, {31'd0, m_err});
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] s, input logic t, input logic [7:0] fw,
                       input logic [7:0] mem, input logic st);
    pc_src = s; b_take = t; target_fw = fw; target_mem = mem; stall = st;
    #1;
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_pc", pc, 8'h00);
    chk("rst_fv", fetch_valid, 1'b0);
    chk("rst_cnt", redirect_cnt, 8'h00);
    chk("rst_err", src_err, 1'b0);
    rst_n = 1'b1;
    drive(2'd1, 1'b1, 8'h99, 8'h00, 1'b1);
    chk("boot_pc", pc, 8'h00);
    chk("boot_fv", fetch_valid, 1'b0);
    chk("boot_flush_ignored", flush, 1'b0);
    tick();
    drive(2'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("boot_vec_pc", pc, 8'h40);
    chk("boot_vec_fv", fetch_valid, 1'b1);
    tick();
    chk("norm_pc", pc, 8'h41);
    drive(2'd1, 1'b1, 8'h90, 8'h00, 1'b1);
    chk("jz_flush", flush, 1'b1);
    tick();
    drive(2'd1, 1'b0, 8'h10, 8'h00, 1'b0);
    chk("jz_pc", pc, 8'h90);
    chk("jz_cnt", redirect_cnt, 8'h01);
    chk("fw_nottaken_flush", flush, 1'b0);
    tick();
    chk("fw_nottaken_pc", pc, 8'h91);
    drive(2'd2, 1'b0, 8'h00, 8'h23, 1'b0);
    chk("ret_flush", flush, 1'b1);
    tick();
    drive(2'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("ret_pc", pc, 8'h23);
    chk("ret_flush_off", flush, 1'b0);
    chk("ret_cnt", redirect_cnt, 8'h02);
    drive(2'd1, 1'b1, 8'hFE, 8'h00, 1'b0);
    tick();
    drive(2'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("wrap_start", pc, 8'hFE);
    tick();
    chk("wrap_ff", pc, 8'hFF);
    chk("wrap_plus1", pc_plus1, 8'h00);
    tick();
    chk("wrap_00", pc, 8'h00);
    drive(2'd0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 8'h00);
      chk("stall_flush", flush, 1'b0);
    end
    drive(2'd3, 1'b1, 8'h55, 8'h66, 1'b0);
    chk("rsvd_flush", flush, 1'b0);
    tick();
    drive(2'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("rsvd_pc_hold", pc, 8'h00);
    chk("rsvd_err", src_err, 1'b1);
    tick();
    chk("rsvd_err_sticky", src_err, 1'b1);
    chk("rsvd_cnt_unchanged", redirect_cnt, 8'h03);
    for (int i = 0; i < 300; i++) begin
      drive(i[0] ? 2'd2 : 2'd1, 1'b1, i[7:0], ~i[7:0], 1'b0);
      tick();
    end
    drive(2'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("sat_cnt", redirect_cnt, 8'hFF);
    chk("sat_err", src_err, 1'b1);
    drive(2'd1, 1'b1, 8'h77, 8'h00, 1'b0);
    chk("midrst_flush_pre", flush, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_flush", flush, 1'b0);
    chk("midrst_fv", fetch_valid, 1'b0);
    chk("midrst_cnt", redirect_cnt, 8'h00);
    chk("midrst_err", src_err, 1'b0);
    tick();
    chk("midrst_no_redirect", pc, 8'h00);
    imem_rdata = 8'h55;
    rst_n = 1'b1;
    #1;
    chk("reboot_pc", pc, 8'h00);
    chk("reboot_flush", flush, 1'b0);
    tick();
    drive(2'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("reboot_vec", pc, 8'h55);
    chk("reboot_fv", fetch_valid, 1'b1);
    tick();
    chk("reboot_norm", pc, 8'h56);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program-counter and address width in bits.
REQ-002 SHALL have parameter BOOT_ADDR, default 8'h00, meaning the instruction-memory address that holds the start vector.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port pc_src  input  2  meaning next-PC select from the branch unit: 00 NORM, 01 FW, 10 DataB, 11 reserved.
REQ-006 SHALL have port b_take  input  1  meaning the branch unit has resolved a taken redirect.
REQ-007 SHALL have port target_fw  input  PC_W  meaning the forwarded register target for JZ/JN/JC/JV/LOOP/JMP/CALL.
REQ-008 SHALL have port target_mem  input  PC_W  meaning the return address read from data memory for RET/RTI.
REQ-009 SHALL have port stall  input  1  meaning a hazard-unit hold request.
REQ-010 SHALL have port imem_rdata  input  PC_W  meaning combinational instruction-memory read data at address pc.
REQ-011 SHALL have port pc  output  PC_W  meaning the current fetch address.
REQ-012 SHALL have port pc_plus1  output  PC_W  meaning pc+1 mod 2^PC_W, used as the CALL link value.
REQ-013 SHALL have port flush  output  1  meaning squash the IF/ID contents this cycle.
REQ-014 SHALL have port fetch_valid  output  1  meaning the word at pc is a real instruction.
REQ-015 SHALL have port redirect_cnt  output  8  meaning the saturating count of redirects applied.
REQ-016 SHALL have port src_err  output  1  meaning a sticky flag set by a reserved pc_src value.

Function
REQ-017 SHALL implement a two-state FSM with states BOOT and RUN; BOOT is entered on reset.
REQ-018 In BOOT: pc SHALL be BOOT_ADDR, fetch_valid 0, flush 0, and all branch and stall inputs SHALL be ignored.
REQ-019 On the first clock edge in BOOT, pc SHALL load imem_rdata and the FSM SHALL move to RUN; BOOT lasts exactly one cycle.
REQ-020 In RUN, fetch_valid SHALL be 1.
REQ-021 RUN, pc_src=01 with b_take=1: pc SHALL load target_fw on the next edge.
REQ-022 RUN, pc_src=10: pc SHALL load target_mem on the next edge; b_take is don't-care.
REQ-023 RUN, pc_src=01 with b_take=0: the cycle SHALL be treated as NORM.
REQ-024 RUN, NORM with stall=0: pc SHALL advance to pc+1; 0xFF SHALL wrap to 0x00 with no flag.
REQ-025 RUN, NORM with stall=1: pc SHALL hold.
REQ-026 Redirects (REQ-021, REQ-022) SHALL take priority over stall.
REQ-027 flush SHALL be combinational, 1 in exactly the cycles where a redirect is applied, otherwise 0.
REQ-028 pc_src=11 in RUN: pc SHALL hold, flush SHALL be 0, and src_err SHALL set on the next edge and stay set until reset.
REQ-029 redirect_cnt SHALL increment on each applied redirect and saturate at 0xFF.
REQ-030 pc_plus1 SHALL be combinational from pc in every state.

Reset
REQ-031 rst_n low SHALL immediately force: state BOOT, pc=BOOT_ADDR, fetch_valid=0, flush=0, redirect_cnt=0, src_err=0.
REQ-032 A reset asserted mid-RUN, including during a redirect cycle, SHALL abandon that redirect; after release, the boot sequence SHALL run again.

Structure
REQ-033 The pc_src encodings (NORM, FW, DataB, reserved) and the FSM state encodings SHALL reside in a shared package also used by the branch unit.
REQ-034 No sub-module is required; the next-PC mux, FSM and counter SHALL be in one module.

Verification
REQ-035 Boot: hold rst_n low, then release with imem_rdata=0x40 -> first cycle pc=0x00 and fetch_valid=0; next cycle pc=0x40 and fetch_valid=1.
REQ-036 Taken JZ: at pc=0x41 apply pc_src=01, b_take=1, target_fw=0x90 with stall=1 -> flush=1 that cycle; next cycle pc=0x90; redirect_cnt=1.
REQ-037 RET: apply pc_src=10, target_mem=0x23 -> pc=0x23 next cycle; flush=1 for one cycle.
REQ-038 Wrap and stall: with pc=0xFE, run NORM for 2 cycles -> pc=0xFF then 0x00; then 3 cycles with stall=1 -> pc stays 0x00 and flush=0.
REQ-039 Reserved and saturation: apply pc_src=11 -> pc holds and src_err=1 sticky; apply 300 redirects -> redirect_cnt=0xFF.
REQ-040 Mid-run reset: assert rst_n low during a FW redirect -> pc=0x00 immediately with no redirect applied; boot repeats after release.
